// File: rtl/pair_accum.sv
// Frame accumulator: sums FRAME_LEN signed samples, then holds a saturated 16-bit result until taken.
// Optional feature macro: PAIR_ACCUM_ROUND_EN (round-half-up arithmetic right shift by SHIFT before saturation).
module pair_accum #(
  parameter int FRAME_LEN = 8,
  parameter int SHIFT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [12:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               out_sat,
  output logic               busy
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic signed [20:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] data_q, data_d;
  logic               sat_q, sat_d;

  logic               accept;
  logic               handshake;
  logic               lastSample;
  logic signed [20:0] sum;
  logic signed [21:0] scaled;
  logic signed [15:0] satVal;
  logic               satFlag;

  assign accept     = in_valid && (state_q == ACCUM);
  assign handshake  = (state_q == HOLD) && out_ready;
  assign lastSample = (cnt_q == CW'(FRAME_LEN - 1));
  assign sum        = acc_q + {{8{in_data[12]}}, in_data};

`ifdef PAIR_ACCUM_ROUND_EN
  localparam logic signed [21:0] ROUND = 22'sd1 <<< (SHIFT - 1);
  assign scaled = ($signed({sum[20], sum}) + ROUND) >>> SHIFT;
`else
  assign scaled = $signed({sum[20], sum});
`endif

  // Clamp the (optionally scaled) frame sum into the 16-bit output range.
  always_comb begin
    satVal  = scaled[15:0];
    satFlag = 1'b0;
    if (scaled > 22'sd32767) begin
      satVal  = 16'sh7FFF;
      satFlag = 1'b1;
    end else if (scaled < -22'sd32768) begin
      satVal  = 16'sh8000;
      satFlag = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    if (accept) begin
      acc_d = sum;
      if (lastSample) begin
        cnt_d   = '0;
        state_d = HOLD;
        data_d  = satVal;
        sat_d   = satFlag;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // The exit cycle never accepts, since in_ready is low throughout HOLD.
    if (handshake) begin
      acc_d   = '0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign busy      = (state_q == ACCUM) && (cnt_q != '0);

endmodule

// File: tb/tb_pair_accum.sv
// Self-checking bench for pair_accum: a FRAME_LEN=4 and a FRAME_LEN=16 instance, scoreboard of expected frames.
module tb_pair_accum;
  localparam int SHIFT_P = 2;

  logic clk = 1'b0;
  logic rst;

  logic               inValid4, inReady4, outValid4, outReady4, outSat4, busy4;
  logic signed [12:0] inData4;
  logic signed [15:0] outData4;

  logic               inValid16, inReady16, outValid16, outReady16, outSat16, busy16;
  logic signed [12:0] inData16;
  logic signed [15:0] outData16;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  pair_accum #(.FRAME_LEN(4), .SHIFT(SHIFT_P)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(inValid4), .in_ready(inReady4), .in_data(inData4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .out_sat(outSat4), .busy(busy4)
  );

  pair_accum #(.FRAME_LEN(16), .SHIFT(SHIFT_P)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid16), .in_ready(inReady16), .in_data(inData16),
    .out_valid(outValid16), .out_ready(outReady16), .out_data(outData16),
    .out_sat(outSat16), .busy(busy16)
  );

  // Reference result for a completed frame sum: {sat, data}
  function automatic logic [16:0] modelFrame(input int total);
    int r;
    r = total;
`ifdef PAIR_ACCUM_ROUND_EN
    r = (total + (1 << (SHIFT_P - 1))) >>> SHIFT_P;
`endif
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, r[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample and wait (bounded) for it to be accepted; in_valid is left high.
  task automatic applyStimulus(input int sel, input logic signed [12:0] d);
    bit ok;
    bit ready;
    ok = 1'b0;
    if (sel == 0) begin inValid4 = 1'b1; inData4 = d; end
    else          begin inValid16 = 1'b1; inData16 = d; end
    for (int n = 0; n < 40 && !ok; n++) begin
      ready = (sel == 0) ? inReady4 : inReady16;
      @(posedge clk); #1;
      if (ready) ok = 1'b1;
    end
    checkOutput("accept", 32'(ok), 32'd1);
  endtask

  task automatic checkFrame(input int sel, input string tag);
    logic [16:0] exp;
    logic [16:0] obs;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      obs = (sel == 0) ? {outSat4, outData4} : {outSat16, outData16};
      checkOutput(tag, 32'(obs), 32'(exp));
    end
  endtask

  initial begin
    rst = 1'b1;
    inValid4 = 1'b0; inData4 = '0; outReady4 = 1'b1;
    inValid16 = 1'b0; inData16 = '0; outReady16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(outValid4), 32'd0);
    checkOutput("rst_out_data", 32'(outData4), 32'd0);
    checkOutput("rst_out_sat", 32'(outSat4), 32'd0);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady4), 32'd1);
    rst = 1'b0;

    // Basic frame: 100, 200, -50, 10 back-to-back
    sb.push_back(modelFrame(100 + 200 - 50 + 10));
    applyStimulus(0, 13'sd100);
    checkOutput("busy_mid", 32'(busy4), 32'd1);
    applyStimulus(0, 13'sd200);
    applyStimulus(0, -13'sd50);
    checkOutput("no_early_valid", 32'(outValid4), 32'd0);
    applyStimulus(0, 13'sd10);
    inValid4 = 1'b0;
    checkOutput("latency_valid", 32'(outValid4), 32'd1);
    checkOutput("hold_in_ready", 32'(inReady4), 32'd0);
    checkOutput("hold_busy", 32'(busy4), 32'd0);
    checkFrame(0, "frame_basic");
    @(posedge clk); #1;
    checkOutput("valid_drop", 32'(outValid4), 32'd0);

    // Backpressure: out_ready low for 3 cycles with in_valid held high
    outReady4 = 1'b0;
    sb.push_back(modelFrame(1 + 2 + 3 + 4));
    applyStimulus(0, 13'sd1);
    applyStimulus(0, 13'sd2);
    applyStimulus(0, 13'sd3);
    applyStimulus(0, 13'sd4);
    inData4 = 13'sd99;
    checkFrame(0, "frame_bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", 32'(outValid4), 32'd1);
      checkOutput("bp_in_ready", 32'(inReady4), 32'd0);
      checkOutput("bp_stable", 32'({outSat4, outData4}), 32'(modelFrame(10)));
    end
    outReady4 = 1'b1;
    @(posedge clk); #1;
    checkOutput("exit_valid", 32'(outValid4), 32'd0);
    checkOutput("exit_no_accept", 32'(busy4), 32'd0);
    checkOutput("exit_in_ready", 32'(inReady4), 32'd1);
    @(posedge clk); #1;
    checkOutput("resume_accept", 32'(busy4), 32'd1);
    sb.push_back(modelFrame(99 + 1 + 1 + 1));
    applyStimulus(0, 13'sd1);
    applyStimulus(0, 13'sd1);
    applyStimulus(0, 13'sd1);
    inValid4 = 1'b0;
    checkOutput("resume_valid", 32'(outValid4), 32'd1);
    checkFrame(0, "frame_resume");
    @(posedge clk); #1;

    // Reset mid-frame discards the partial sum
    applyStimulus(0, 13'sd500);
    applyStimulus(0, 13'sd600);
    inValid4 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy4), 32'd0);
    checkOutput("midrst_valid", 32'(outValid4), 32'd0);
    sb.push_back(modelFrame(10));
    applyStimulus(0, 13'sd1);
    applyStimulus(0, 13'sd2);
    applyStimulus(0, 13'sd3);
    checkOutput("midrst_no_early", 32'(outValid4), 32'd0);
    applyStimulus(0, 13'sd4);
    inValid4 = 1'b0;
    checkOutput("midrst_valid_out", 32'(outValid4), 32'd1);
    checkFrame(0, "frame_after_rst");
    @(posedge clk); #1;

    // Saturation on the 16-sample instance
    sb.push_back(modelFrame(16 * 4095));
    for (int i = 0; i < 16; i++) applyStimulus(1, 13'sd4095);
    inValid16 = 1'b0;
    checkOutput("sat_pos_valid", 32'(outValid16), 32'd1);
    checkFrame(1, "frame_sat_pos");
    @(posedge clk); #1;
    sb.push_back(modelFrame(16 * -4096));
    for (int i = 0; i < 16; i++) applyStimulus(1, -13'sd4096);
    inValid16 = 1'b0;
    checkOutput("sat_neg_valid", 32'(outValid16), 32'd1);
    checkFrame(1, "frame_sat_neg");
    @(posedge clk); #1;
    checkOutput("sat_drop", 32'(outValid16), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pair_accum.md
PAIR_ACCUM -- requirements
Module: pair_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of samples summed per frame, legal range 2..256.
REQ-002 SHALL have parameter SHIFT, default 2: right-shift amount applied when PAIR_ACCUM_ROUND_EN is defined, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-007 SHALL have port in_data, input, 13 bits, signed: upstream two-product sum.
REQ-008 SHALL have port out_valid, output, 1 bit: frame result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port out_data, output, 16 bits, signed: frame result.
REQ-011 SHALL have port out_sat, output, 1 bit: out_data was clamped.
REQ-012 SHALL have port busy, output, 1 bit: at least one sample of the current frame has been accepted.

Function
REQ-013 SHALL implement two states, ACCUM and HOLD; reset state is ACCUM.
REQ-014 SHALL assert in_ready exactly when state==ACCUM; a sample is accepted only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL, on each accepted sample, add sign-extended in_data to a 21-bit signed accumulator and increment a sample counter; the accumulator SHALL never overflow internally.
REQ-016 SHALL, when the accepted sample is number FRAME_LEN (counter at FRAME_LEN-1), clear the counter, register the result, and enter HOLD; out_valid SHALL rise on the next clock edge, giving 1-cycle latency from the last accept.
REQ-017 SHALL saturate the result to 16 bits: greater than 32767 gives 32767, less than -32768 gives -32768, and out_sat SHALL be 1 for a clamped frame and 0 otherwise.
REQ-018 SHALL hold out_valid, out_data and out_sat stable in HOLD until out_valid and out_ready are both 1.
REQ-019 SHALL, on the HOLD handshake cycle, clear the accumulator, deassert out_valid on the next edge, and return to ACCUM.
REQ-020 SHALL NOT accept a sample on the HOLD-exit cycle, even if in_valid is 1; acceptance resumes on the following cycle.
REQ-021 SHALL drive busy=1 when state==ACCUM and counter!=0, and busy=0 otherwise.
REQ-022 SHALL ignore out_ready while in ACCUM.
REQ-023 SHALL leave samples unaccepted while in_valid=1 and in_ready=0; holding the sample stable is the upstream's responsibility.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set state=ACCUM, accumulator=0, counter=0, out_valid=0, out_data=0, out_sat=0 and busy=0; in_ready SHALL be 1 from the next cycle.
REQ-025 SHALL discard any partial frame or pending result when reset is applied mid-operation, with no output generated for it.
REQ-026 SHALL give rst priority over any handshake occurring in the same cycle.

Configuration
REQ-027 SHALL define a macro PAIR_ACCUM_ROUND_EN; with it defined, the result is (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up) before saturation.
REQ-028 SHALL, without PAIR_ACCUM_ROUND_EN, saturate the raw accumulator with no shift and no rounding logic synthesised.

Verification
REQ-029 SHALL cover: FRAME_LEN=4, macro off, inputs 100, 200, -50, 10 back-to-back with out_ready=1 -> out_valid=1 one cycle after the 4th accept, out_data=260, out_sat=0.
REQ-030 SHALL cover: the same stimulus, macro on, SHIFT=2 -> out_data=65.
REQ-031 SHALL cover: FRAME_LEN=16, macro off -> sixteen inputs of 4095 give out_data=32767 with out_sat=1, and sixteen inputs of -4096 give out_data=-32768 with out_sat=1.
REQ-032 SHALL cover: FRAME_LEN=4, out_ready=0 for 3 cycles after out_valid with in_valid held at 1 -> in_ready=0, out_data stable, and the first new accept occurs 2 cycles after out_ready rises.
REQ-033 SHALL cover: FRAME_LEN=4, rst pulsed after 2 accepts, then inputs 1, 2, 3, 4 -> out_data=10 with no earlier out_valid.
